// File: rtl/std_pipe_addsub.sv
// Pipelined add/subtract unit with go/done handshake, carry/borrow and signed-overflow flags.
// Optional unsigned saturation is enabled by defining STD_PIPE_ADDSUB_SAT_EN.
module std_pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic             op,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  input  logic             stall,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             ovf,
  output logic             done,
  output logic             busy
);

  logic [WIDTH:0]   raw;
  logic [WIDTH-1:0] res_in;
  logic             carry_in;
  logic             ovf_in;
  logic             launch;

  assign launch = go & ~stall;

  // Zero-extended WIDTH+1 arithmetic: bit WIDTH is carry for add and borrow for sub.
  always_comb begin
    raw      = op ? ({1'b0, left} - {1'b0, right}) : ({1'b0, left} + {1'b0, right});
    carry_in = raw[WIDTH];
    if (op)
      ovf_in = (left[WIDTH-1] != right[WIDTH-1]) && (raw[WIDTH-1] != left[WIDTH-1]);
    else
      ovf_in = (left[WIDTH-1] == right[WIDTH-1]) && (raw[WIDTH-1] != left[WIDTH-1]);
`ifdef STD_PIPE_ADDSUB_SAT_EN
    if (carry_in)
      res_in = op ? '0 : '1;
    else
      res_in = raw[WIDTH-1:0];
`else
    res_in = raw[WIDTH-1:0];
`endif
  end

  logic             tail_vld;
  logic [WIDTH-1:0] tail_res;
  logic             tail_carry;
  logic             tail_ovf;
  logic             pipe_busy;

  generate
    if (STAGES == 1) begin : g_direct
      assign tail_vld   = launch;
      assign tail_res   = res_in;
      assign tail_carry = carry_in;
      assign tail_ovf   = ovf_in;
      assign pipe_busy  = 1'b0;
    end else begin : g_pipe
      localparam int unsigned N = STAGES - 1;

      logic [N-1:0]     vld;
      logic [WIDTH-1:0] res_q [N];
      logic [N-1:0]     carry_q;
      logic [N-1:0]     ovf_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          vld <= '0;
        end else if (!stall) begin
          vld[0] <= launch;
          for (int unsigned i = 1; i < N; i++)
            vld[i] <= vld[i-1];
        end
      end

      always_ff @(posedge clk) begin
        if (!stall) begin
          res_q[0]   <= res_in;
          carry_q[0] <= carry_in;
          ovf_q[0]   <= ovf_in;
          for (int unsigned i = 1; i < N; i++) begin
            res_q[i]   <= res_q[i-1];
            carry_q[i] <= carry_q[i-1];
            ovf_q[i]   <= ovf_q[i-1];
          end
        end
      end

      assign tail_vld   = vld[N-1];
      assign tail_res   = res_q[N-1];
      assign tail_carry = carry_q[N-1];
      assign tail_ovf   = ovf_q[N-1];
      assign pipe_busy  = |vld;
    end
  endgenerate

  // Output stage: payload only moves when a valid result arrives, so out holds between completions.
  always_ff @(posedge clk) begin
    if (reset) begin
      out   <= '0;
      carry <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (!stall && tail_vld) begin
        out   <= tail_res;
        carry <= tail_carry;
        ovf   <= tail_ovf;
        done  <= 1'b1;
      end
    end
  end

  assign busy = ~reset & (launch | pipe_busy);

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!reset)
      assert (!(go && stall)) else $error("std_pipe_addsub: go issued while stall is high");
  end
`endif

endmodule

// File: tb/tb_std_pipe_addsub.sv
// Self-checking bench for std_pipe_addsub: a WIDTH=32/STAGES=2 instance against a queue-based
// latency model, plus a WIDTH=8/STAGES=1 instance checked directly.
module tb_std_pipe_addsub;

  localparam int W  = 32;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          go, op, stall;
  logic [W-1:0]  left, right;
  logic [W-1:0]  out;
  logic          carry, ovf, done, busy;

  logic          go8, op8, stall8;
  logic [7:0]    left8, right8, out8;
  logic          carry8, ovf8, done8, busy8;

  always #5 clk = ~clk;

  std_pipe_addsub #(.WIDTH(W), .STAGES(ST)) dut (
    .clk(clk), .reset(reset), .go(go), .op(op), .left(left), .right(right), .stall(stall),
    .out(out), .carry(carry), .ovf(ovf), .done(done), .busy(busy)
  );

  std_pipe_addsub #(.WIDTH(8), .STAGES(1)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .op(op8), .left(left8), .right(right8), .stall(stall8),
    .out(out8), .carry(carry8), .ovf(ovf8), .done(done8), .busy(busy8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [W-1:0] r;
    bit           c;
    bit           v;
    int           cnt;
  } item_t;

  item_t        q[$];
  logic [W-1:0] exp_out;
  bit           exp_c, exp_v, exp_done, exp_busy;
  logic         obs_busy;

  // Reference arithmetic from plain integer rules: unsigned carry/borrow, signed range overflow.
  function automatic void calc(input int unsigned w, input bit o, input longint unsigned a,
                               input longint unsigned b, output longint unsigned r,
                               output bit c, output bit v);
    longint unsigned mask, half;
    longint sa, sb, sr;
    mask = (64'd1 << w) - 64'd1;
    half = 64'd1 << (w - 1);
    sa = (a >= half) ? longint'(a) - longint'(half << 1) : longint'(a);
    sb = (b >= half) ? longint'(b) - longint'(half << 1) : longint'(b);
    if (o) begin
      r  = (a - b) & mask;
      c  = a < b;
      sr = sa - sb;
    end else begin
      r  = (a + b) & mask;
      c  = (a + b) > mask;
      sr = sa + sb;
    end
    v = (sr >= longint'(half)) || (sr < -longint'(half));
`ifdef STD_PIPE_ADDSUB_SAT_EN
    if (c) r = o ? 64'd0 : mask;
`endif
  endfunction

  // One clock of stimulus on the main instance; samples busy mid-cycle and advances the model.
  task automatic drive(input bit g, input bit o, input logic [W-1:0] l, input logic [W-1:0] r,
                       input bit s, input bit rst);
    longint unsigned res;
    bit c, v;
    item_t it;
    go = g; op = o; left = l; right = r; stall = s; reset = rst;
    exp_busy = !rst && (q.size() > 0 || (g && !s));
    #3;
    obs_busy = busy;
    @(posedge clk);
    if (rst) begin
      q.delete();
      exp_out = '0; exp_c = 0; exp_v = 0; exp_done = 0;
    end else if (s) begin
      exp_done = 0;
    end else begin
      foreach (q[i]) q[i].cnt++;
      if (g) begin
        calc(W, o, longint'(l), longint'(r), res, c, v);
        it.r = res[W-1:0]; it.c = c; it.v = v; it.cnt = 1;
        q.push_back(it);
      end
      exp_done = 0;
      if (q.size() > 0 && q[0].cnt == ST) begin
        exp_done = 1;
        exp_out = q[0].r; exp_c = q[0].c; exp_v = q[0].v;
        void'(q.pop_front());
      end
    end
    #1;
    go = 0;
  endtask

  task automatic test_reset();
    drive(0, 0, '0, '0, 0, 1);
    drive(0, 0, '0, '0, 0, 1);
    n_checks++;
    if ({done, carry, ovf, out, busy} !== {1'b0, 1'b0, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_state: got done=%b c=%b v=%b out=%h busy=%b, expected all 0",
               done, carry, ovf, out, busy);
    else n_pass++;
    n_checks++;
    if ({done8, carry8, ovf8, out8, busy8} !== 12'd0)
      $display("FAIL reset_state8: got done=%b c=%b v=%b out=%h busy=%b, expected all 0",
               done8, carry8, ovf8, out8, busy8);
    else n_pass++;
    drive(0, 0, '0, '0, 0, 0);
  endtask

  task automatic test_basic();
    bit           g_t [12];
    bit           o_t [12];
    logic [W-1:0] l_t [12];
    logic [W-1:0] r_t [12];
    logic [W-1:0] want_out [4];
    bit           want_c [4];
    bit           want_v [4];
    int           k = 0;
    for (int i = 0; i < 12; i++) begin g_t[i] = 0; o_t[i] = 0; l_t[i] = '0; r_t[i] = '0; end
    g_t[0] = 1; o_t[0] = 1; l_t[0] = 32'd10;         r_t[0] = 32'd3;
    g_t[3] = 1; o_t[3] = 1; l_t[3] = 32'd0;          r_t[3] = 32'd7;
    g_t[6] = 1; o_t[6] = 0; l_t[6] = 32'h7FFF_FFFF;  r_t[6] = 32'd1;
    g_t[9] = 1; o_t[9] = 0; l_t[9] = 32'hFFFF_FFFF;  r_t[9] = 32'd1;
`ifdef STD_PIPE_ADDSUB_SAT_EN
    want_out[0] = 32'd7; want_out[1] = 32'd0; want_out[2] = 32'h8000_0000; want_out[3] = 32'hFFFF_FFFF;
`else
    want_out[0] = 32'd7; want_out[1] = 32'hFFFF_FFF9; want_out[2] = 32'h8000_0000; want_out[3] = 32'd0;
`endif
    want_c[0] = 0; want_c[1] = 1; want_c[2] = 0; want_c[3] = 1;
    want_v[0] = 0; want_v[1] = 0; want_v[2] = 1; want_v[3] = 0;
    for (int i = 0; i < 12; i++) begin
      drive(g_t[i], o_t[i], l_t[i], r_t[i], 0, 0);
      n_checks++;
      if (obs_busy !== exp_busy)
        $display("FAIL basic_busy[%0d]: got %b expected %b", i, obs_busy, exp_busy);
      else n_pass++;
      n_checks++;
      if ({done, carry, ovf, out} !== {exp_done, exp_c, exp_v, exp_out})
        $display("FAIL basic_result[%0d]: got done=%b c=%b v=%b out=%h expected done=%b c=%b v=%b out=%h",
                 i, done, carry, ovf, out, exp_done, exp_c, exp_v, exp_out);
      else n_pass++;
      if (done === 1'b1 && k < 4) begin
        n_checks++;
        if ({carry, ovf, out} !== {want_c[k], want_v[k], want_out[k]})
          $display("FAIL basic_vector[%0d]: got c=%b v=%b out=%h expected c=%b v=%b out=%h",
                   k, carry, ovf, out, want_c[k], want_v[k], want_out[k]);
        else n_pass++;
        k++;
      end
    end
    n_checks++;
    if (k != 4) $display("FAIL basic_done_count: got %0d expected 4", k);
    else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    bit           g_t [12] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0};
    bit           s_t [12] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    logic [W-1:0] v_t [12] = '{1, 2, 0, 0, 0, 3, 4, 0, 0, 0, 0, 0};
    logic [W-1:0] seen [$];
    logic [W-1:0] held;
    for (int i = 0; i < 12; i++) begin
      held = out;
      drive(g_t[i], 0, v_t[i], v_t[i], s_t[i], 0);
      n_checks++;
      if ({done, carry, ovf, out, obs_busy} !== {exp_done, exp_c, exp_v, exp_out, exp_busy})
        $display("FAIL stall_step[%0d]: got done=%b out=%h busy=%b expected done=%b out=%h busy=%b",
                 i, done, out, obs_busy, exp_done, exp_out, exp_busy);
      else n_pass++;
      if (s_t[i]) begin
        n_checks++;
        if (out !== held || done !== 1'b0)
          $display("FAIL stall_hold[%0d]: got out=%h done=%b expected out=%h done=0", i, out, done, held);
        else n_pass++;
      end
      if (done === 1'b1) seen.push_back(out);
    end
    n_checks++;
    if (seen.size() != 4 || seen[0] !== 32'd2 || seen[1] !== 32'd4 || seen[2] !== 32'd6 || seen[3] !== 32'd8)
      $display("FAIL stall_order: got %0d done pulses, expected 4 with out 2,4,6,8", seen.size());
    else n_pass++;
  endtask

  task automatic test_reset_mid_op();
    int dones = 0;
    drive(1, 0, 32'd5, 32'd5, 0, 0);
    drive(0, 0, '0, '0, 0, 1);
    n_checks++;
    if ({done, carry, ovf, out, busy} !== {1'b0, 1'b0, 1'b0, 32'd0, 1'b0})
      $display("FAIL reset_mid_clear: got done=%b out=%h busy=%b expected all 0", done, out, busy);
    else n_pass++;
    for (int i = 0; i < 5; i++) begin
      drive(0, 0, '0, '0, 0, 0);
      if (done === 1'b1) dones++;
      n_checks++;
      if (obs_busy !== 1'b0 || out !== 32'd0)
        $display("FAIL reset_mid_idle[%0d]: got busy=%b out=%h expected busy=0 out=0", i, obs_busy, out);
      else n_pass++;
    end
    n_checks++;
    if (dones != 0) $display("FAIL reset_mid_done: got %0d done pulses expected 0", dones);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] corner [5] = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h1};
    logic [W-1:0] a, b;
    bit s, g;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom % 5) == 0;
      g = !s && ($urandom % 3 != 0);
      a = ($urandom % 4 == 0) ? corner[$urandom % 5] : $urandom;
      b = ($urandom % 4 == 0) ? corner[$urandom % 5] : $urandom;
      drive(g, $urandom % 2, a, b, s, 0);
      n_checks++;
      if ({done, carry, ovf, out, obs_busy} !== {exp_done, exp_c, exp_v, exp_out, exp_busy})
        $display("FAIL random[%0d]: got done=%b c=%b v=%b out=%h busy=%b expected done=%b c=%b v=%b out=%h busy=%b",
                 i, done, carry, ovf, out, obs_busy, exp_done, exp_c, exp_v, exp_out, exp_busy);
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) drive(0, 0, '0, '0, 0, 0);
  endtask

  task automatic test_stages1();
    longint unsigned r;
    bit c, v, o;
    logic [7:0] a, b;
    go8 = 1; op8 = 0; left8 = 8'hF0; right8 = 8'h20;
    #3;
    n_checks++;
    if (busy8 !== 1'b1) $display("FAIL s1_busy: got %b expected 1", busy8);
    else n_pass++;
    @(posedge clk); #1; go8 = 0;
    n_checks++;
`ifdef STD_PIPE_ADDSUB_SAT_EN
    if ({done8, carry8, out8} !== {1'b1, 1'b1, 8'hFF})
`else
    if ({done8, carry8, out8} !== {1'b1, 1'b1, 8'h10})
`endif
      $display("FAIL s1_directed: got done=%b c=%b out=%h", done8, carry8, out8);
    else n_pass++;
    for (int i = 0; i < 40; i++) begin
      o = $urandom % 2; a = $urandom; b = $urandom;
      calc(8, o, longint'(a), longint'(b), r, c, v);
      go8 = (i % 4 != 3); op8 = o; left8 = a; right8 = b;
      @(posedge clk); #1; go8 = 0;
      n_checks++;
      if (i % 4 != 3) begin
        if ({done8, carry8, ovf8, out8} !== {1'b1, c, v, r[7:0]})
          $display("FAIL s1_random[%0d]: got done=%b c=%b v=%b out=%h expected done=1 c=%b v=%b out=%h",
                   i, done8, carry8, ovf8, out8, c, v, r[7:0]);
        else n_pass++;
      end else begin
        if (done8 !== 1'b0) $display("FAIL s1_idle[%0d]: got done=%b expected 0", i, done8);
        else n_pass++;
      end
    end
  endtask

  initial begin
    reset = 1; go = 0; op = 0; stall = 0; left = '0; right = '0;
    go8 = 0; op8 = 0; stall8 = 0; left8 = '0; right8 = '0;
    exp_out = '0; exp_c = 0; exp_v = 0; exp_done = 0; exp_busy = 0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_back_to_back_stall();
    test_reset_mid_op();
    test_random();
    test_stages1();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
